// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 16x oversampled, 1 start bit,
// 5..8 data bits (LSB first), optional parity bit, 1 stop bit.
// Optional feature macro: UART_RX_PARITY_EN adds parity_odd / parity_err
// and a PARITY state between DATA and STOP.
//
// Output handshake: there is no ready input. rx_valid (and frame_err /
// parity_err) are single-cycle strobes; the consumer must take rx_data in
// the cycle rx_valid is high. rx_data stays stable until the next good frame.
module uart_rx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       En,
    input  logic [3:0] databit,
    input  logic       RXD,
`ifdef UART_RX_PARITY_EN
    input  logic       parity_odd,
    output logic       parity_err,
`endif
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            rxd_m;
    logic            rxd_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      os_cnt;
    logic [2:0]      bit_cnt;
    logic [3:0]      nbits;
    logic [3:0]      db_eff;
    logic [7:0]      shreg;
    logic            armed;
    logic            sample;
    logic            last_bit;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
    logic            par_ok;
`endif

    // tick on divider wrap; sample at mid start bit (8th tick) or every 16th tick after
    assign tick     = (div_cnt == DIV_MAX);
    assign sample   = tick && (os_cnt == ((state == START) ? 4'd7 : 4'd15));
    assign last_bit = ({1'b0, bit_cnt} == (nbits - 4'd1));
    assign db_eff   = (databit >= 4'd5 && databit <= 4'd8) ? databit : 4'd8;
`ifdef UART_RX_PARITY_EN
    // received parity agrees with selected sense (upper shreg bits are zero)
    assign par_ok   = (((^shreg) ^ par_bit) == parity_odd);
`endif

    // two-flop synchronizer for the asynchronous RXD pin, idle-high reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= RXD;
            rxd_s <= rxd_m;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next-state logic; En low forces IDLE from anywhere
    always_comb begin
        state_nx = state;
        if (!En) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:   if (armed && !rxd_s) state_nx = START;
                START:  if (sample) state_nx = rxd_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                DATA:   if (sample && last_bit) state_nx = PARITY;
                PARITY: if (sample) state_nx = STOP;
`else
                DATA:   if (sample && last_bit) state_nx = STOP;
`endif
                STOP:   if (sample) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // FSM outputs: busy whenever a frame is in progress
    always_comb begin
        busy = (state != IDLE);
    end

    // tick divider, oversample counter, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            os_cnt  <= 4'd0;
            bit_cnt <= 3'd0;
            nbits   <= 4'd8;
            shreg   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (!En || state == IDLE) begin
            // held at zero so ticks are phase-aligned to the start edge
            div_cnt <= '0;
            os_cnt  <= 4'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                os_cnt <= (state == START && os_cnt == 4'd7) ? 4'd0 : os_cnt + 4'd1;
            end
            if (state == START && sample) begin
                nbits   <= db_eff;
                bit_cnt <= 3'd0;
                shreg   <= 8'd0;
            end
            if (state == DATA && sample) begin
                shreg[bit_cnt] <= rxd_s;
                bit_cnt        <= bit_cnt + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && sample) par_bit <= rxd_s;
`endif
        end
    end

    // armed: line seen high in IDLE; cleared by a framing error so a break fires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (En && state == STOP && sample && !rxd_s) begin
            armed <= 1'b0;
        end else if (state == IDLE && rxd_s) begin
            armed <= 1'b1;
        end
    end

    // result strobes and output byte, registered at the stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (En && state == STOP && sample) begin
                if (!rxd_s) begin
                    frame_err <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                else if (!par_ok) begin
                    parity_err <= 1'b1;
                end
`endif
                else begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule
